// File: rtl/bp_common_pkg.sv
// ============================================================================
// bp_common_pkg : configuration enums, widths and the ME message macro
// Revision: 1.0
// ============================================================================
`default_nettype none

`define DECLARE_BP_ME_IF(paddr_width_mp, data_width_mp, lce_id_width_mp) \
   typedef struct packed {                                               \
      logic [data_width_mp-1:0]   data;                                  \
      logic [paddr_width_mp-1:0]  addr;                                  \
      logic [lce_id_width_mp-1:0] lce_id;                                \
      logic [3:0]                 msg_type;                              \
   } bp_cce_mem_msg_s;

package bp_common_pkg;

   typedef enum logic [1:0] {
      e_bp_inv_cfg       = 2'd0,
      e_bp_half_core_cfg = 2'd1
   } bp_params_e;

   typedef enum logic [1:0] {
      e_src_clint = 2'd0,
      e_src_io    = 2'd1,
      e_src_mem   = 2'd2
   } bp_resp_src_e;

   localparam int num_src_gp        = 3;
   localparam int num_dest_gp       = 2;
   localparam int lce_id_width_gp   = 4;
   localparam int msg_type_width_gp = 4;

   function automatic int paddr_width(input bp_params_e cfg);
      return (cfg == e_bp_inv_cfg) ? 40 : 32;
   endfunction

   function automatic int data_width(input bp_params_e cfg);
      return (cfg == e_bp_inv_cfg) ? 64 : 32;
   endfunction

   function automatic int cce_mem_msg_width(input bp_params_e cfg);
      return data_width(cfg) + paddr_width(cfg) + lce_id_width_gp + msg_type_width_gp;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_resp_rr_arb.sv
// ============================================================================
// bp_resp_rr_arb : 3-way round-robin arbiter with a one-hot last-grant register
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_resp_rr_arb
   import bp_common_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic [num_src_gp-1:0] req_i,
   output logic [num_src_gp-1:0] grant_o
);

   localparam logic [num_src_gp-1:0] last_rst_lp = 3'b100;

   logic [num_src_gp-1:0] last_q, last_d;

   // Search starts at the source just after the previous winner.
   always_comb begin
      grant_o = '0;
      case (last_q)
         3'b001: begin
            if      (req_i[1]) grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
         end
         3'b010: begin
            if      (req_i[2]) grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
         end
         default: begin
            if      (req_i[0]) grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
         end
      endcase
      if (!en_i) begin
         grant_o = '0;
      end
      last_d = (|grant_o) ? grant_o : last_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q <= last_rst_lp;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bsg_two_fifo.sv
// ============================================================================
// bsg_two_fifo : 2-entry FIFO; ready_o also admits a write while full and dequeuing
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_q [2];
   logic [width_p-1:0] mem_d [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               enq, deq;

   assign v_o     = (cnt_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign ready_o = (cnt_q != 2'd2) | yumi_i;
   assign deq     = yumi_i & v_o;
   assign enq     = v_i & ready_o;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (enq) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (deq) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/bp_softcore_resp_router.sv
// ============================================================================
// bp_softcore_resp_router : routes CLINT/IO/MEM responses to the I$/D$ UCEs
// Option macro: BP_SOFTCORE_RESP_ROUTER_BAD_ID_EN (drain illegal lce_id, flag bad_id_o)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_softcore_resp_router
   import bp_common_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_inv_cfg,
   localparam int cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
   input  logic                                             clk_i,
   input  logic                                             reset_i,
   input  logic [cce_mem_msg_width_lp-1:0]                  clint_resp_i,
   input  logic                                             clint_resp_v_i,
   output logic                                             clint_resp_yumi_o,
   input  logic [cce_mem_msg_width_lp-1:0]                  io_resp_i,
   input  logic                                             io_resp_v_i,
   output logic                                             io_resp_yumi_o,
   input  logic [cce_mem_msg_width_lp-1:0]                  mem_resp_i,
   input  logic                                             mem_resp_v_i,
   output logic                                             mem_resp_yumi_o,
   output logic [num_dest_gp-1:0][cce_mem_msg_width_lp-1:0] lce_resp_o,
   output logic [num_dest_gp-1:0]                           lce_resp_v_o,
   input  logic [num_dest_gp-1:0]                           lce_resp_yumi_i,
   output logic                                             bad_id_o
);

   `DECLARE_BP_ME_IF(paddr_width(bp_params_p), data_width(bp_params_p), lce_id_width_gp)

   bp_cce_mem_msg_s [num_src_gp-1:0]             src_msg;
   logic [num_src_gp-1:0]                        src_v, src_bad, src_dest, src_yumi;
   logic [num_dest_gp-1:0][num_src_gp-1:0]       req, grant;
   logic [num_dest_gp-1:0]                       fifo_ready, fifo_v;

   assign src_msg = {mem_resp_i, io_resp_i, clint_resp_i};
   assign src_v   = {mem_resp_v_i, io_resp_v_i, clint_resp_v_i};

   always_comb begin
      src_bad  = '0;
      src_dest = '0;
      req      = '0;
      for (int s = 0; s < num_src_gp; s++) begin
         src_dest[s] = src_msg[s].lce_id[0];
`ifdef BP_SOFTCORE_RESP_ROUTER_BAD_ID_EN
         src_bad[s]  = src_v[s] & (|src_msg[s].lce_id[lce_id_width_gp-1:1]);
`endif
         for (int d = 0; d < num_dest_gp; d++) begin
            req[d][s] = src_v[s] & ~src_bad[s] & (src_dest[s] == 1'(d));
         end
      end
   end

   for (genvar d = 0; d < num_dest_gp; d++) begin : g_dest
      logic [cce_mem_msg_width_lp-1:0] data_in;

      bp_resp_rr_arb arb (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .en_i    (fifo_ready[d] & ~reset_i),
         .req_i   (req[d]),
         .grant_o (grant[d])
      );

      always_comb begin
         data_in = '0;
         for (int s = 0; s < num_src_gp; s++) begin
            if (grant[d][s]) begin
               data_in = data_in | src_msg[s];
            end
         end
      end

      bsg_two_fifo #(
         .width_p (cce_mem_msg_width_lp)
      ) fifo (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .ready_o (fifo_ready[d]),
         .data_i  (data_in),
         .v_i     (|grant[d]),
         .v_o     (fifo_v[d]),
         .data_o  (lce_resp_o[d]),
         .yumi_i  (lce_resp_yumi_i[d] & fifo_v[d])
      );

      // FIFO state clears on the reset edge; mask the cycle before it lands.
      assign lce_resp_v_o[d] = fifo_v[d] & ~reset_i;
   end

   assign src_yumi = grant[0] | grant[1] | (src_bad & {num_src_gp{~reset_i}});

   assign clint_resp_yumi_o = src_yumi[e_src_clint];
   assign io_resp_yumi_o    = src_yumi[e_src_io];
   assign mem_resp_yumi_o   = src_yumi[e_src_mem];

`ifdef BP_SOFTCORE_RESP_ROUTER_BAD_ID_EN
   logic bad_id_q, bad_id_d;

   always_comb begin
      bad_id_d = bad_id_q | (|src_bad);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         bad_id_q <= 1'b0;
      end else begin
         bad_id_q <= bad_id_d;
      end
   end

   assign bad_id_o = bad_id_q & ~reset_i;
`else
   assign bad_id_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_softcore_resp_router.sv
// ============================================================================
// tb_bp_softcore_resp_router : directed + random bench with per-source scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bp_softcore_resp_router;
   import bp_common_pkg::*;

   localparam bp_params_e cfg_lp = e_bp_inv_cfg;
   localparam int         w_lp   = cce_mem_msg_width(cfg_lp);

   `DECLARE_BP_ME_IF(paddr_width(cfg_lp), data_width(cfg_lp), lce_id_width_gp)

   logic                  clk = 1'b0;
   logic                  reset;
   logic [2:0]            src_v;
   bp_cce_mem_msg_s       src_msg [3];
   logic [2:0]            src_yumi;
   logic [1:0][w_lp-1:0]  lce_resp;
   logic [1:0]            lce_v;
   logic [1:0]            lce_yumi;
   logic                  bad_id;

   always #5 clk = ~clk;

   bp_softcore_resp_router #(.bp_params_p(cfg_lp)) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .clint_resp_i      (src_msg[0]),
      .clint_resp_v_i    (src_v[0]),
      .clint_resp_yumi_o (src_yumi[0]),
      .io_resp_i         (src_msg[1]),
      .io_resp_v_i       (src_v[1]),
      .io_resp_yumi_o    (src_yumi[1]),
      .mem_resp_i        (src_msg[2]),
      .mem_resp_v_i      (src_v[2]),
      .mem_resp_yumi_o   (src_yumi[2]),
      .lce_resp_o        (lce_resp),
      .lce_resp_v_o      (lce_v),
      .lce_resp_yumi_i   (lce_yumi),
      .bad_id_o          (bad_id)
   );

   int              n_assert = 0;
   int              n_fail   = 0;
   int              n_out    = 0;
   int              seq [3];
   bp_cce_mem_msg_s sb_q [3][2][$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // New message on source s for lce; expectation queued as it is driven.
   task automatic offer(input int s, input int lce);
      bp_cce_mem_msg_s m;
      m.data     = {$urandom, $urandom};
      m.addr     = 40'(seq[s]);
      m.lce_id   = 4'(lce);
      m.msg_type = 4'(s);
      seq[s]++;
      src_msg[s] = m;
      src_v[s]   = 1'b1;
`ifdef BP_SOFTCORE_RESP_ROUTER_BAD_ID_EN
      if (lce < 2) sb_q[s][lce].push_back(m);
`else
      sb_q[s][lce % 2].push_back(m);
`endif
   endtask

   // Called at a negedge: score outputs, then retire accepted sources after the edge.
   task automatic advance();
      logic [2:0] took;
      for (int d = 0; d < 2; d++) begin
         if (lce_v[d] && lce_yumi[d]) begin
            bp_cce_mem_msg_s got;
            int              s;
            got = lce_resp[d];
            s   = int'(got.msg_type);
            n_out++;
            check("sb_src_tag", (s < 3), 1'b1);
            if (s < 3) begin
               check("sb_not_empty", (sb_q[s][d].size() > 0), 1'b1);
               if (sb_q[s][d].size() > 0) check("sb_data", got, sb_q[s][d].pop_front());
            end
         end
      end
      check("yumi_only_when_v", src_yumi & ~src_v, 3'b000);
      took = src_yumi;
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) if (took[s]) src_v[s] = 1'b0;
   endtask

   task automatic step_chk(input string tag, input logic [2:0] ey, input logic [1:0] ev);
      @(negedge clk);
      check({tag, "_yumi"}, src_yumi, ey);
      check({tag, "_v"}, lce_v, ev);
      advance();
   endtask

   initial begin
      int wait_cnt [3];
      int max_wait;
      max_wait = 0;
      reset    = 1'b1;
      src_v    = 3'b000;
      lce_yumi = 2'b00;
      for (int s = 0; s < 3; s++) begin
         src_msg[s]  = '0;
         seq[s]      = 0;
         wait_cnt[s] = 0;
      end
      @(posedge clk);
      #1;
      src_v = 3'b111;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rst_v", lce_v, 2'b00);
         check("rst_yumi", src_yumi, 3'b000);
         check("rst_bad_id", bad_id, 1'b0);
         @(posedge clk);
         #1;
      end
      src_v = 3'b000;
      reset = 1'b0;

      // Three-way contention on lce 1 drains in clint, io, mem order.
      offer(0, 1); offer(1, 1); offer(2, 1);
      lce_yumi = 2'b10;
      step_chk("rr_c0", 3'b001, 2'b00);
      step_chk("rr_c1", 3'b010, 2'b10);
      step_chk("rr_c2", 3'b100, 2'b10);
      step_chk("rr_c3", 3'b000, 2'b10);
      step_chk("rr_c4", 3'b000, 2'b00);

      // Two destinations granting different sources in one cycle.
      offer(2, 0); offer(1, 1);
      lce_yumi = 2'b11;
      step_chk("dual_c0", 3'b110, 2'b00);
      step_chk("dual_c1", 3'b000, 2'b11);
      step_chk("dual_c2", 3'b000, 2'b00);

      // Backpressure: FIFO fills at 2, third held, accepted on full enq+deq.
      lce_yumi = 2'b00;
      offer(2, 0);
      step_chk("bp_m1", 3'b100, 2'b00);
      offer(2, 0);
      step_chk("bp_m2", 3'b100, 2'b01);
      offer(2, 0);
      step_chk("bp_hold0", 3'b000, 2'b01);
      step_chk("bp_hold1", 3'b000, 2'b01);
      lce_yumi = 2'b01;
      step_chk("bp_fullrw", 3'b100, 2'b01);
      step_chk("bp_drain0", 3'b000, 2'b01);
      step_chk("bp_drain1", 3'b000, 2'b01);
      step_chk("bp_empty", 3'b000, 2'b00);

      // lce_id = 2 on io.
      offer(1, 2);
`ifdef BP_SOFTCORE_RESP_ROUTER_BAD_ID_EN
      step_chk("badid_drain", 3'b010, 2'b00);
      check("badid_set", bad_id, 1'b1);
      step_chk("badid_noout", 3'b000, 2'b00);
      check("badid_sticky", bad_id, 1'b1);
`else
      step_chk("id2_accept", 3'b010, 2'b00);
      step_chk("id2_to_lce0", 3'b000, 2'b01);
      check("badid_tied", bad_id, 1'b0);
`endif

      // Fill both FIFOs, then reset drops them and restores clint priority.
      lce_yumi = 2'b00;
      offer(0, 0); offer(1, 1);
      step_chk("fill_a", 3'b011, 2'b00);
      offer(0, 0); offer(1, 1);
      step_chk("fill_b", 3'b011, 2'b11);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_v", lce_v, 2'b00);
      check("midrst_yumi", src_yumi, 3'b000);
      advance();
      reset = 1'b0;
      for (int s = 0; s < 3; s++) for (int d = 0; d < 2; d++) sb_q[s][d].delete();
      step_chk("postrst", 3'b000, 2'b00);
      offer(0, 0); offer(2, 0); offer(1, 1);
      lce_yumi = 2'b11;
      step_chk("postrst_c0", 3'b011, 2'b00);
      step_chk("postrst_c1", 3'b100, 2'b11);
      step_chk("postrst_c2", 3'b000, 2'b01);
      step_chk("postrst_c3", 3'b000, 2'b00);

      // Random valid/ready traffic.
      for (int c = 0; c < 1000; c++) begin
         for (int s = 0; s < 3; s++) begin
            if (!src_v[s] && ($urandom_range(0, 3) != 0)) offer(s, $urandom_range(0, 1));
         end
         lce_yumi = 2'($urandom_range(0, 3));
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            if (src_v[s] && !src_yumi[s]) wait_cnt[s]++;
            else wait_cnt[s] = 0;
            if (wait_cnt[s] > max_wait) max_wait = wait_cnt[s];
         end
         advance();
      end
      lce_yumi = 2'b11;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         advance();
      end
      check("drain_src_idle", src_v, 3'b000);
      check("drain_out_idle", lce_v, 2'b00);
      for (int s = 0; s < 3; s++) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("sb_empty_%0d_%0d", s, d), sb_q[s][d].size(), 0);
         end
      end
      check("no_starve", (max_wait <= 64), 1'b1);
      check("outputs_seen", (n_out > 300), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
